// File: rtl/mux_pkg.sv
// Shared types for the 4:1 mux select path: select codes, arbiter states,
// and a select-to-grant decoder.
package mux_pkg;

   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned SEL_W   = 2;

   typedef logic [SEL_W-1:0] sel_t;

   localparam sel_t SEL_A = 2'b00;
   localparam sel_t SEL_B = 2'b01;
   localparam sel_t SEL_C = 2'b10;
   localparam sel_t SEL_D = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // One-hot grant vector for a select code
   function automatic logic [NUM_SRC-1:0] sel_onehot(input sel_t s);
      return NUM_SRC'(1) << s;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin priority search: the first set request after ptr wins,
// with ptr itself searched last.
module rr_pick4
   import mux_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] win,
   output logic       any
);

   sel_t idx;
   logic found;

   always_comb begin
      win   = ptr;
      idx   = ptr;
      found = 1'b0;
      any   = |req;
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
         idx = sel_t'(ptr + sel_t'(i));
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for the 4:1 data mux; holds each grant for a
// bounded burst under a valid/ready handshake with the mux consumer.
module mux_sel_arbiter
   import mux_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned CNT_W     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] last,
   input  logic       out_ready,
   output logic [1:0] sel,
   output logic       sel_valid,
   output logic [3:0] grant,
   output logic       beat
);

   arb_state_t       state_q, state_d;
   sel_t             sel_q, sel_d;
   sel_t             ptr_q, ptr_d;
   logic             valid_q, valid_d;
   logic [3:0]       grant_q, grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   sel_t             pick_win;
   logic             pick_any;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr_q),
      .win (pick_win),
      .any (pick_any)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= SEL_A;
         ptr_q   <= SEL_D;
         valid_q <= 1'b0;
         grant_q <= 4'b0000;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: grant on any request, release on last, burst limit or dropped request
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               sel_d   = pick_win;
               grant_d = sel_onehot(pick_win);
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            // A dropped request releases without counting the beat
            if (!req[sel_q]) begin
               ptr_d   = sel_q;
               valid_d = 1'b0;
               grant_d = 4'b0000;
               state_d = IDLE;
            end else if (out_ready) begin
               if (last[sel_q] || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
                  ptr_d   = sel_q;
                  valid_d = 1'b0;
                  grant_d = 4'b0000;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sel       = sel_q;
   assign sel_valid = valid_q;
   assign grant     = grant_q;
   assign beat      = valid_q & out_ready;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: behavioural reference model with
// a scoreboard queue, directed scenarios and a random phase.
module tb_mux_sel_arbiter;

   localparam int unsigned MAX_BURST = 4;
   localparam int unsigned CNT_W     = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] last;
   logic       out_ready;
   logic [1:0] sel;
   logic       sel_valid;
   logic [3:0] grant;
   logic       beat;

   mux_sel_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .last      (last),
      .out_ready (out_ready),
      .sel       (sel),
      .sel_valid (sel_valid),
      .grant     (grant),
      .beat      (beat)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned beat_cnt = 0;

   // Reference model state
   logic       m_valid = 1'b0;
   logic [1:0] m_sel   = 2'b00;
   logic [1:0] m_ptr   = 2'b11;
   logic [3:0] m_grant = 4'b0000;
   int         m_cnt   = 0;

   logic [6:0] exp_q[$];
   logic [3:0] gq[$];
   logic [3:0] prev_grant = 4'b0000;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                             input logic rd);
      logic [1:0] cand;
      logic       done;
      if (r) begin
         m_valid = 1'b0; m_sel = 2'b00; m_ptr = 2'b11; m_grant = 4'b0000; m_cnt = 0;
      end else if (!m_valid) begin
         done = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            cand = 2'((int'(m_ptr) + k) % 4);
            if (!done && rq[cand]) begin
               done    = 1'b1;
               m_sel   = cand;
               m_grant = 4'(1 << cand);
               m_valid = 1'b1;
               m_cnt   = 0;
            end
         end
      end else if (!rq[m_sel]) begin
         m_ptr = m_sel; m_valid = 1'b0; m_grant = 4'b0000;
      end else if (rd) begin
         m_cnt++;
         if (ls[m_sel] || m_cnt == int'(MAX_BURST)) begin
            m_ptr = m_sel; m_valid = 1'b0; m_grant = 4'b0000;
         end
      end
   endtask

   // One clock: drive at negedge, check beat before the edge, registers after it
   task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] ls, input logic rd);
      logic [6:0] e;
      rst = r; req = rq; last = ls; out_ready = rd;
      #1;
      chk("beat", 32'(beat), 32'(m_valid & rd));
      if (beat === 1'b1) beat_cnt++;
      model_edge(r, rq, ls, rd);
      exp_q.push_back({m_sel, m_valid, m_grant});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("regs", 32'({sel, sel_valid, grant}), 32'(e));
      if (grant !== 4'b0000 && prev_grant === 4'b0000) gq.push_back(grant);
      prev_grant = grant;
      @(negedge clk);
   endtask

   task automatic do_reset();
      step(1'b1, 4'b0000, 4'b0000, 1'b0);
      beat_cnt = 0;
      gq.delete();
   endtask

   initial begin
      rst = 1'b1; req = '0; last = '0; out_ready = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);

      // Reset state
      do_reset();
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_valid", 32'(sel_valid), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);

      // Single source, full burst of MAX_BURST beats
      step(1'b0, 4'b0001, 4'b0000, 1'b1);
      chk("t1_valid", 32'(sel_valid), 32'd1);
      chk("t1_sel", 32'(sel), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 4'b0001, 4'b0000, 1'b1);
      chk("t1_rel_valid", 32'(sel_valid), 32'd0);
      chk("t1_rel_grant", 32'(grant), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 4'b0000, 1'b1);
      chk("t1_beats", beat_cnt, 32'd4);

      // All requesting: strict rotation with one bubble between grants
      do_reset();
      for (int i = 0; i < 23; i++) step(1'b0, 4'b1111, 4'b0000, 1'b1);
      chk("t2_ngrants", gq.size(), 32'd5);
      if (gq.size() >= 5) begin
         chk("t2_g0", 32'(gq[0]), 32'h1);
         chk("t2_g1", 32'(gq[1]), 32'h2);
         chk("t2_g2", 32'(gq[2]), 32'h4);
         chk("t2_g3", 32'(gq[3]), 32'h8);
         chk("t2_g4", 32'(gq[4]), 32'h1);
      end

      // Backpressure on source 2 holds the grant and the beat count
      do_reset();
      step(1'b0, 4'b0100, 4'b0000, 1'b0);
      step(1'b0, 4'b0100, 4'b0000, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, 4'b0100, 4'b0000, 1'b0);
      chk("t3_sel", 32'(sel), 32'd2);
      chk("t3_valid", 32'(sel_valid), 32'd1);
      for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 4'b0000, 1'b1);
      chk("t3_rel", 32'(sel_valid), 32'd0);
      step(1'b0, 4'b0000, 4'b0000, 1'b1);
      chk("t3_beats", beat_cnt, 32'd4);

      // last on source 1's second beat; foreign last ignored
      do_reset();
      step(1'b0, 4'b0010, 4'b0000, 1'b0);
      step(1'b0, 4'b0010, 4'b0100, 1'b1);
      chk("t4_hold", 32'(sel_valid), 32'd1);
      step(1'b0, 4'b0010, 4'b0010, 1'b1);
      chk("t4_rel", 32'(sel_valid), 32'd0);
      chk("t4_beats", beat_cnt, 32'd2);
      step(1'b0, 4'b0111, 4'b0000, 1'b0);
      chk("t4_next", 32'(grant), 32'h4);

      // Source 3 drops its request mid-burst
      do_reset();
      step(1'b0, 4'b1000, 4'b0000, 1'b0);
      step(1'b0, 4'b1000, 4'b0000, 1'b1);
      step(1'b0, 4'b0000, 4'b0000, 1'b1);
      chk("t5_rel", 32'(sel_valid), 32'd0);
      step(1'b0, 4'b1001, 4'b0000, 1'b0);
      chk("t5_next", 32'(grant), 32'h1);

      // Reset mid-burst wins over everything
      do_reset();
      step(1'b0, 4'b0010, 4'b0000, 1'b0);
      step(1'b0, 4'b0010, 4'b0000, 1'b1);
      step(1'b0, 4'b0010, 4'b0000, 1'b1);
      step(1'b1, 4'b0010, 4'b0010, 1'b1);
      chk("t6_sel", 32'(sel), 32'd0);
      chk("t6_valid", 32'(sel_valid), 32'd0);
      chk("t6_grant", 32'(grant), 32'd0);
      step(1'b0, 4'b0011, 4'b0000, 1'b0);
      chk("t6_next", 32'(grant), 32'h1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 63) == 0), 4'($urandom), 4'($urandom),
              1'($urandom_range(0, 3) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
